// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and ALU operand select, with MEM/WB forwarding and load-use bubble insertion.
// Build macro ID_EX_FORWARD_EN enables forwarding and load-use detection; without it operands come straight from the register.

`ifdef ID_EX_FORWARD_EN
module id_ex_fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] idx,
    input  logic [DATA_W-1:0] regVal,
    input  logic              memRegWrite,
    input  logic [REG_AW-1:0] memWriteReg,
    input  logic [DATA_W-1:0] memAluRes,
    input  logic              wbRegWrite,
    input  logic [REG_AW-1:0] wbWriteReg,
    input  logic [DATA_W-1:0] wbWriteData,
    output logic [DATA_W-1:0] operand
);
    // MEM is the younger producer, so it wins over WB; r0 is hardwired zero.
    always_comb begin
        operand = regVal;
        if (idx != '0) begin
            if (memRegWrite && memWriteReg == idx)
                operand = memAluRes;
            else if (wbRegWrite && wbWriteReg == idx)
                operand = wbWriteData;
        end
    end
endmodule
`endif

module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTR_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              idValid,
    input  logic [DATA_W-1:0] idReadData1,
    input  logic [DATA_W-1:0] idReadData2,
    input  logic [DATA_W-1:0] idImm,
    input  logic [CTR_W-1:0]  idAluCtr,
    input  logic              idAluSrc,
    input  logic [REG_AW-1:0] idRs,
    input  logic [REG_AW-1:0] idRt,
    input  logic [REG_AW-1:0] idRd,
    input  logic              idRegDst,
    input  logic              idRegWrite,
    input  logic              idMemRead,
    input  logic              idMemWrite,
    input  logic              idMemToReg,
    input  logic              memRegWrite,
    input  logic [REG_AW-1:0] memWriteReg,
    input  logic [DATA_W-1:0] memAluRes,
    input  logic              wbRegWrite,
    input  logic [REG_AW-1:0] wbWriteReg,
    input  logic [DATA_W-1:0] wbWriteData,
    output logic              exValid,
    output logic [DATA_W-1:0] aluInput1,
    output logic [DATA_W-1:0] aluInput2,
    output logic [CTR_W-1:0]  aluCtr,
    output logic [DATA_W-1:0] exStoreData,
    output logic [REG_AW-1:0] exWriteReg,
    output logic              exRegWrite,
    output logic              exMemRead,
    output logic              exMemWrite,
    output logic              exMemToReg,
    output logic              loadUseStall
);
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [CTR_W-1:0]  aluCtr;
        logic              aluSrc;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] writeReg;
        logic              regWrite;
        logic              memRead;
        logic              memWrite;
        logic              memToReg;
    } ex_reg_t;

    ex_reg_t ex, idCap;

    always_comb begin
        idCap          = '0;
        idCap.valid    = idValid;
        idCap.rd1      = idReadData1;
        idCap.rd2      = idReadData2;
        idCap.imm      = idImm;
        idCap.aluCtr   = idAluCtr;
        idCap.aluSrc   = idAluSrc;
        idCap.rs       = idRs;
        idCap.rt       = idRt;
        idCap.writeReg = idRegDst ? idRd : idRt;
        idCap.regWrite = idRegWrite;
        idCap.memRead  = idMemRead;
        idCap.memWrite = idMemWrite;
        idCap.memToReg = idMemToReg;
    end

    // A bubble is the all-zero record; flush and load-use share one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ex <= '0;
        else if (!stall) begin
            if (flush || loadUseStall)
                ex <= '0;
            else
                ex <= idCap;
        end
    end

    logic [1:0][REG_AW-1:0] srcIdx;
    logic [1:0][DATA_W-1:0] srcVal;
    logic [1:0][DATA_W-1:0] fwdVal;

    assign srcIdx = {ex.rt, ex.rs};
    assign srcVal = {ex.rd2, ex.rd1};

`ifdef ID_EX_FORWARD_EN
    for (genvar g = 0; g < 2; g++) begin : g_fwd
        id_ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd (
            .idx        (srcIdx[g]),
            .regVal     (srcVal[g]),
            .memRegWrite(memRegWrite),
            .memWriteReg(memWriteReg),
            .memAluRes  (memAluRes),
            .wbRegWrite (wbRegWrite),
            .wbWriteReg (wbWriteReg),
            .wbWriteData(wbWriteData),
            .operand    (fwdVal[g])
        );
    end

    // rt compare is conservative: I-type instructions may stall needlessly.
    assign loadUseStall = !stall && ex.valid && ex.memRead && (ex.writeReg != '0) && idValid &&
                          ((ex.writeReg == idRs) || (ex.writeReg == idRt));
`else
    assign fwdVal       = srcVal;
    assign loadUseStall = 1'b0;

    logic unused_fwd;
    assign unused_fwd = ^{memRegWrite, memWriteReg, memAluRes, wbRegWrite, wbWriteReg,
                          wbWriteData, srcIdx};
`endif

    assign exValid     = ex.valid;
    assign aluInput1   = fwdVal[0];
    assign aluInput2   = ex.aluSrc ? ex.imm : fwdVal[1];
    assign exStoreData = fwdVal[1];
    assign aluCtr      = ex.aluCtr;
    assign exWriteReg  = ex.writeReg;
    assign exRegWrite  = ex.regWrite;
    assign exMemRead   = ex.memRead;
    assign exMemWrite  = ex.memWrite;
    assign exMemToReg  = ex.memToReg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expectations cover both the forwarding and the plain build.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        reset, stall, flush, idValid;
    logic [31:0] idReadData1, idReadData2, idImm;
    logic [3:0]  idAluCtr;
    logic        idAluSrc, idRegDst, idRegWrite, idMemRead, idMemWrite, idMemToReg;
    logic [4:0]  idRs, idRt, idRd;
    logic        memRegWrite, wbRegWrite;
    logic [4:0]  memWriteReg, wbWriteReg;
    logic [31:0] memAluRes, wbWriteData;
    logic        exValid, exRegWrite, exMemRead, exMemWrite, exMemToReg, loadUseStall;
    logic [31:0] aluInput1, aluInput2, exStoreData;
    logic [3:0]  aluCtr;
    logic [4:0]  exWriteReg;

    int nvec = 0;
    int nerr = 0;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .idValid(idValid),
        .idReadData1(idReadData1), .idReadData2(idReadData2), .idImm(idImm),
        .idAluCtr(idAluCtr), .idAluSrc(idAluSrc), .idRs(idRs), .idRt(idRt), .idRd(idRd),
        .idRegDst(idRegDst), .idRegWrite(idRegWrite), .idMemRead(idMemRead),
        .idMemWrite(idMemWrite), .idMemToReg(idMemToReg),
        .memRegWrite(memRegWrite), .memWriteReg(memWriteReg), .memAluRes(memAluRes),
        .wbRegWrite(wbRegWrite), .wbWriteReg(wbWriteReg), .wbWriteData(wbWriteData),
        .exValid(exValid), .aluInput1(aluInput1), .aluInput2(aluInput2), .aluCtr(aluCtr),
        .exStoreData(exStoreData), .exWriteReg(exWriteReg), .exRegWrite(exRegWrite),
        .exMemRead(exMemRead), .exMemWrite(exMemWrite), .exMemToReg(exMemToReg),
        .loadUseStall(loadUseStall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // valid, rs, rt, rd, rd1, rd2, imm, ctr, aluSrc, regDst, regWrite, memRead, memWrite, memToReg
    task automatic put_id(input logic v, input logic [4:0] rs, rt, rd,
                          input logic [31:0] d1, d2, imm, input logic [3:0] ctr,
                          input logic src, dst, rw, mr, mw, m2r);
        idValid = v; idRs = rs; idRt = rt; idRd = rd;
        idReadData1 = d1; idReadData2 = d2; idImm = imm; idAluCtr = ctr;
        idAluSrc = src; idRegDst = dst; idRegWrite = rw;
        idMemRead = mr; idMemWrite = mw; idMemToReg = m2r;
    endtask

    task automatic put_fwd(input logic mrw, input logic [4:0] mreg, input logic [31:0] mres,
                           input logic wrw, input logic [4:0] wreg, input logic [31:0] wdat);
        memRegWrite = mrw; memWriteReg = mreg; memAluRes = mres;
        wbRegWrite = wrw; wbWriteReg = wreg; wbWriteData = wdat;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        put_id(1'b0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
        put_fwd(0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_valid", {31'b0, exValid}, 0);
        chk("rst_ctl", {27'b0, exRegWrite, exMemRead, exMemWrite, exMemToReg, loadUseStall}, 0);
        chk("rst_data", aluInput1 | aluInput2 | exStoreData | {23'b0, aluCtr, exWriteReg}, 0);
        reset = 1'b0;

        // ADD r3 = r1 + r2
        put_id(1, 1, 2, 3, 32'h5, 32'h7, 32'h0, 4'b0010, 0, 1, 1, 0, 0, 0);
        tick();
        chk("add_in1", aluInput1, 32'h5);
        chk("add_in2", aluInput2, 32'h7);
        chk("add_ctr", {28'b0, aluCtr}, 32'h2);
        chk("add_wreg", {27'b0, exWriteReg}, 32'd3);
        chk("add_vld", {30'b0, exValid, exRegWrite}, 32'h3);

        // asynchronous reset while a real instruction sits in EX
        #2 reset = 1'b1;
        #1;
        chk("arst_vld", {30'b0, exValid, exRegWrite}, 0);
        chk("arst_in1", aluInput1, 0);
        #1 reset = 1'b0;
        tick();
        chk("post_rst_vld", {31'b0, exValid}, 1);
        chk("post_rst_in1", aluInput1, 32'h5);

        // rs=3 with both MEM and WB targeting r3
        put_id(1, 3, 5, 6, 32'hAA, 32'hBB, 0, 4'b0010, 0, 1, 1, 0, 0, 0);
        tick();
        put_fwd(1, 3, 32'h11, 1, 3, 32'h22);
        #1 chk("fwd_mem", aluInput1, FWD ? 32'h11 : 32'hAA);
        memRegWrite = 1'b0;
        #1 chk("fwd_wb", aluInput1, FWD ? 32'h22 : 32'hAA);
        chk("fwd_rt_none", aluInput2, 32'hBB);
        put_fwd(0, 0, 0, 0, 0, 0);

        // rs=0 is never forwarded
        put_id(1, 0, 5, 6, 32'h33, 32'hBB, 0, 4'b0010, 0, 1, 1, 0, 0, 0);
        tick();
        put_fwd(1, 0, 32'h11, 1, 0, 32'h22);
        #1 chk("fwd_r0", aluInput1, 32'h33);
        put_fwd(0, 0, 0, 0, 0, 0);

        // LW r4 <- 8(r1), then SUB r7 = r4 - r2
        put_id(1, 1, 4, 9, 32'h100, 32'h0, 32'h8, 4'b0010, 1, 0, 1, 1, 0, 1);
        tick();
        chk("lw_wreg", {27'b0, exWriteReg}, 32'd4);
        chk("lw_in2_imm", aluInput2, 32'h8);
        put_id(1, 4, 2, 7, 32'h40, 32'h50, 0, 4'b0110, 0, 1, 1, 0, 0, 0);
        stall = 1'b1;
        #1 chk("lu_masked_by_stall", {31'b0, loadUseStall}, 0);
        stall = 1'b0;
        #1 chk("lu_req", {31'b0, loadUseStall}, {31'b0, FWD});
        tick();
        chk("lu_bubble", {30'b0, exValid, exRegWrite}, FWD ? 32'h0 : 32'h3);
        chk("lu_once", {31'b0, loadUseStall}, 0);
        tick();
        chk("sub_ctr", {28'b0, aluCtr}, 32'h6);
        chk("sub_vld", {31'b0, exValid}, 1);
        chk("sub_in1", aluInput1, 32'h40);

        // stall three cycles while ID churns
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            put_id(1, 5'(10 + i), 5'(11 + i), 5'(12 + i), 32'(i), 32'(i), 0, 4'b0001, 1, 0, 1, 1, 1, 1);
            tick();
            chk("stall_in1", aluInput1, 32'h40);
            chk("stall_ctr_wreg", {23'b0, aluCtr, exWriteReg}, {23'b0, 4'b0110, 5'd7});
        end
        stall = 1'b0;

        // flush turns the next capture into a bubble
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_vld", {30'b0, exValid, exRegWrite}, 0);
        chk("flush_ctr", {28'b0, aluCtr}, 0);

        // store: immediate on input2, forwarded rt on store data
        put_id(1, 1, 9, 0, 32'h3, 32'h1, 32'hFFFF_FFFC, 4'b0010, 1, 0, 0, 0, 1, 0);
        tick();
        put_fwd(1, 9, 32'h9, 0, 0, 0);
        #1 chk("st_in2_imm", aluInput2, 32'hFFFF_FFFC);
        chk("st_data_mem", exStoreData, FWD ? 32'h9 : 32'h1);
        chk("st_memwrite", {31'b0, exMemWrite}, 1);
        put_fwd(0, 0, 0, 1, 9, 32'h77);
        #1 chk("st_data_wb", exStoreData, FWD ? 32'h77 : 32'h1);
        put_fwd(0, 0, 0, 0, 0, 0);

        // reset during a pending load-use hazard
        put_id(1, 1, 6, 0, 0, 0, 32'h4, 4'b0010, 1, 0, 1, 1, 0, 1);
        tick();
        put_id(1, 2, 6, 8, 0, 0, 0, 4'b0000, 0, 1, 1, 0, 0, 0);
        #1 chk("hz_req", {31'b0, loadUseStall}, {31'b0, FWD});
        reset = 1'b1;
        #1 chk("hz_rst", {30'b0, exValid, loadUseStall}, 0);
        reset = 1'b0;
        tick();
        chk("hz_after", {28'b0, aluCtr}, 0);
        chk("hz_after_vld", {31'b0, exValid}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage that feeds the 32-bit ALU.
- Captures decoded operands and control from ID. Drives the ALU operands and aluCtr for EX.
- Resolves RAW hazards by forwarding from MEM and WB.
- Detects load-use hazards, requests an upstream stall and inserts a bubble.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register-index width
- CTR_W, 4, ALU control width (encodings as consumed by the ALU: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold all stage registers
- flush  in  1  replace the next captured instruction with a bubble
- idValid  in  1  ID holds a real instruction
- idReadData1  in  DATA_W  rs register value
- idReadData2  in  DATA_W  rt register value
- idImm  in  DATA_W  sign-extended immediate
- idAluCtr  in  CTR_W  ALU operation
- idAluSrc  in  1  1 = operand 2 is the immediate
- idRs, idRt, idRd  in  REG_AW  register indices
- idRegDst  in  1  1 = destination is rd, 0 = destination is rt
- idRegWrite, idMemRead, idMemWrite, idMemToReg  in  1  control bits
- memRegWrite  in  1  MEM-stage instruction writes a register
- memWriteReg  in  REG_AW  MEM-stage destination
- memAluRes  in  DATA_W  MEM-stage ALU result
- wbRegWrite  in  1  WB-stage instruction writes a register
- wbWriteReg  in  REG_AW  WB-stage destination
- wbWriteData  in  DATA_W  WB-stage write data
- exValid  out  1  EX holds a real instruction
- aluInput1  out  DATA_W  ALU input1
- aluInput2  out  DATA_W  ALU input2
- aluCtr  out  CTR_W  ALU control
- exStoreData  out  DATA_W  forwarded rt value for stores
- exWriteReg  out  REG_AW  resolved destination register
- exRegWrite, exMemRead, exMemWrite, exMemToReg  out  1  registered control bits
- loadUseStall  out  1  request to freeze PC and IF/ID

Behaviour:
- Reset: clock is clk; reset is asynchronous and active-high, named reset. While reset is high, every register clears: exValid=0, all control outputs 0, aluCtr=0000, indices 0, data 0. The outputs aluInput1, aluInput2 and exStoreData therefore read 0.
- Register update priority at each rising clk, with reset low:
  1. stall=1: hold everything.
  2. flush=1: load a bubble.
  3. loadUseStall=1: load a bubble.
  4. Otherwise: capture the id* inputs, with exValid=idValid.
- Bubble contents: exValid=0, control bits 0, aluCtr=0000, indices and data 0.
- exWriteReg is resolved at capture: idRd if idRegDst, else idRt.
- Latency: one cycle from ID inputs to EX outputs. Forwarding is combinational on the registered values.
- Forwarding, per source operand (rs for input1, rt for input2 and store data):
  - Forward memAluRes if memRegWrite and memWriteReg==index and index!=0.
  - Else forward wbWriteData if wbRegWrite and wbWriteReg==index and index!=0.
  - Else use the registered value.
  - MEM has priority over WB when both match. Register 0 is never forwarded.
- aluInput2 is the registered immediate when aluSrc=1, otherwise the forwarded rt. exStoreData is always the forwarded rt.
- loadUseStall (combinational) = exValid & exMemRead & exWriteReg!=0 & idValid & (exWriteReg==idRs | exWriteReg==idRt).
  - The rt match counts even for I-type instructions (conservative).
  - Asserts for exactly one cycle per hazard, since the inserted bubble clears exMemRead.
- loadUseStall is forced 0 while stall=1, so no double bubble is inserted.
- Simultaneous flush and loadUseStall: a single bubble is inserted. loadUseStall may still assert that cycle; upstream gives flush precedence.
- Reset mid-stall or mid-hazard: the pipeline is empty afterwards and no stall request persists.

Optional Feature:
- Macro ID_EX_FORWARD_EN.
- Defined: forwarding and load-use detection as above.
- Undefined: no forwarding muxes. Operands come straight from the registers, loadUseStall is tied 0, and software/NOP insertion resolves hazards. The ports stay present; the mem*/wb* inputs are ignored.

Test Plan:
- Reset high mid-operation, with exValid=1 and exRegWrite=1 -> all outputs 0 immediately (asynchronously); after release, the first capture appears one cycle later.
- ADD with rs=1 (0x5), rt=2 (0x7), idAluCtr=0010, idAluSrc=0 -> next cycle aluInput1=5, aluInput2=7, aluCtr=0010, exWriteReg=idRd.
- EX rs=3 with memWriteReg=3 (memAluRes=0x11) and wbWriteReg=3 (wbWriteData=0x22), both writing -> aluInput1=0x11. With memRegWrite=0 -> aluInput1=0x22. With rs=0 -> registered value, never forwarded.
- LW to rt=4 in EX, followed by SUB using rs=4 in ID -> loadUseStall=1 for one cycle; next cycle exValid=0 and exRegWrite=0. Once the ID inputs are held, SUB captures on the following cycle.
- stall=1 for 3 cycles while the id* inputs change -> outputs unchanged. flush=1 -> next cycle bubble (exValid=0, aluCtr=0000).
- idAluSrc=1, idImm=0xFFFFFFFC, forwarded rt=0x9 -> aluInput2=0xFFFFFFFC and exStoreData=0x9.
